// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX handshaked stage: control bundle layout,
// skid buffer state encoding and the bubble control word.
package pipe_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_SPARE    = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic width-W valid/ready register slice. SKID=1 gives a 2-entry skid
// buffer with registered ready_o; SKID=0 gives a single register.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  if (SKID) begin : g_skid
    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q, ready_d;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = data_i;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = data_i;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // The older skid entry moves up; no input is accepted here.
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (flush_i) begin
        state_d = EMPTY;
      end
      ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= EMPTY;
        ready_q <= 1'b1;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        ready_q <= ready_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    assign ready_o = ready_q;
    assign valid_o = (state_q != EMPTY);
    assign data_o  = main_q;
  end else begin : g_reg
    logic         valid_q, valid_d;
    logic [W-1:0] main_q, main_d;

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (in_xfer) begin
        valid_d = 1'b1;
        main_d  = data_i;
      end else if (out_xfer) begin
        valid_d = 1'b0;
      end
      if (flush_i) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = main_q;
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// ID/EX handshaked stage: payload slice plus flush, NOP forcing of the
// control bundle on bubbles and a saturating back-pressure counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [ADDR_W-1:0] rs_addr_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int PAY_W = 3 * DATA_W + 3 * ADDR_W + CTRL_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;
  logic [CTRL_W-1:0] ctrl_held;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign pay_in = {rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i, ctrl_i};

  pipe_skid_buf #(
    .W    (PAY_W),
    .SKID (SKID)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (pay_in),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (pay_out)
  );

  assign {rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, ctrl_held} = pay_out;

  // A bubble must look like a NOP to an EX stage that ignores valid_o.
  assign ctrl_o = valid_o ? ctrl_held : CTRL_W'(CTRL_NOP);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && !ready_i) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a SKID=1/CNT_W=16 instance and a SKID=0/CNT_W=4
// instance share stimulus and are compared against a FIFO-occupancy model.
module tb_pipe_stage_hs;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int PW = 3 * DW + 3 * AW + CW;
  typedef logic [PW-1:0] pay_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, flush = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [DW-1:0] rs_i = '0, rt_i = '0, imm_i = '0;
  logic [AW-1:0] rsa_i = '0, rta_i = '0, rda_i = '0;
  logic [CW-1:0] ctrl_i = '0;

  logic          rdy_o [2];
  logic          vld_o [2];
  logic [DW-1:0] rs_o  [2];
  logic [DW-1:0] rt_o  [2];
  logic [DW-1:0] imm_o [2];
  logic [AW-1:0] rsa_o [2];
  logic [AW-1:0] rta_o [2];
  logic [AW-1:0] rda_o [2];
  logic [CW-1:0] ctrl_o[2];
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  pipe_stage_hs #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(rdy_o[0]),
    .rs_data_i(rs_i), .rt_data_i(rt_i), .imm_i(imm_i),
    .rs_addr_i(rsa_i), .rt_addr_i(rta_i), .rd_addr_i(rda_i), .ctrl_i(ctrl_i),
    .valid_o(vld_o[0]), .ready_i(ready_i),
    .rs_data_o(rs_o[0]), .rt_data_o(rt_o[0]), .imm_o(imm_o[0]),
    .rs_addr_o(rsa_o[0]), .rt_addr_o(rta_o[0]), .rd_addr_o(rda_o[0]),
    .ctrl_o(ctrl_o[0]), .stall_cnt_o(cnt_a)
  );

  pipe_stage_hs #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(rdy_o[1]),
    .rs_data_i(rs_i), .rt_data_i(rt_i), .imm_i(imm_i),
    .rs_addr_i(rsa_i), .rt_addr_i(rta_i), .rd_addr_i(rda_i), .ctrl_i(ctrl_i),
    .valid_o(vld_o[1]), .ready_i(ready_i),
    .rs_data_o(rs_o[1]), .rt_data_o(rt_o[1]), .imm_o(imm_o[1]),
    .rs_addr_o(rsa_o[1]), .rt_addr_o(rta_o[1]), .rd_addr_o(rda_o[1]),
    .ctrl_o(ctrl_o[1]), .stall_cnt_o(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference: each stage is an in-order FIFO of depth 2 (skid) or 1.
  pay_t mem [2][2];
  int   n   [2];
  int   sc  [2];
  bit   known = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sc_max(input int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  function automatic bit model_ready(input int d);
    if (d == 0) return n[0] < 2;
    return (n[1] == 0) || ready_i;
  endfunction

  function automatic pay_t dut_pay(input int d);
    return {rs_o[d], rt_o[d], imm_o[d], rsa_o[d], rta_o[d], rda_o[d], ctrl_o[d]};
  endfunction

  task automatic check_outputs();
    logic [CW-1:0] exp_ctrl;
    if (!known) return;
    for (int d = 0; d < 2; d++) begin
      exp_ctrl = (n[d] > 0) ? mem[d][0][CW-1:0] : '0;
      check_eq($sformatf("ready%0d", d), rdy_o[d], model_ready(d));
      check_eq($sformatf("valid%0d", d), vld_o[d], n[d] > 0);
      check_eq($sformatf("ctrl%0d", d), ctrl_o[d], exp_ctrl);
      check_eq($sformatf("stall%0d", d), (d == 0) ? 16'(cnt_a) : 16'(cnt_b), sc[d]);
      if (n[d] > 0) check_eq($sformatf("payload%0d", d), dut_pay(d), mem[d][0]);
    end
  endtask

  task automatic model_edge();
    pay_t cur;
    bit   inx, outx, vm;
    cur = {rs_i, rt_i, imm_i, rsa_i, rta_i, rda_i, ctrl_i};
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        n[d]  = 0;
        sc[d] = 0;
      end
      known = 1'b1;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      vm   = n[d] > 0;
      inx  = valid_i && model_ready(d);
      outx = vm && ready_i;
      if (vm && !ready_i && sc[d] < sc_max(d)) sc[d]++;
      if (flush) begin
        n[d] = 0;
      end else begin
        if (outx) begin
          mem[d][0] = mem[d][1];
          n[d]--;
        end
        if (inx) begin
          mem[d][n[d]] = cur;
          n[d]++;
        end
      end
    end
  endtask

  task automatic step(input bit v, input bit r, input bit f, input bit rs_,
                      input logic [DW-1:0] rsd, input logic [CW-1:0] c);
    @(negedge clk);
    rst     = rs_;
    flush   = f;
    valid_i = v;
    ready_i = r;
    rs_i    = rsd;
    rt_i    = $urandom;
    imm_i   = $urandom;
    rsa_i   = AW'($urandom);
    rta_i   = AW'($urandom);
    rda_i   = AW'($urandom);
    ctrl_i  = c;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    // Reset with valid_i high: nothing may be captured.
    step(1, 1, 0, 1, 32'h5555, 8'hFF);
    step(1, 1, 0, 1, 32'h6666, 8'hFF);
    #1;
    check_eq("rst_valid", vld_o[0], 1'b0);
    check_eq("rst_ctrl", ctrl_o[0], 8'h00);
    check_eq("rst_rs", rs_o[0], 32'h0);
    check_eq("rst_imm", imm_o[0], 32'h0);
    check_eq("rst_stall", cnt_a, 16'd0);
    step(0, 1, 0, 0, 32'h0, 8'h00);
    #1;
    check_eq("rel_ready", rdy_o[0], 1'b1);

    // Streaming: one entry per cycle, 1-cycle latency, no bubbles.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 32'h11 * (i + 1), 8'h04);
      #1;
      check_eq("stream_valid", vld_o[0], 1'b1);
      check_eq("stream_rs", rs_o[0], 32'h11 * (i + 1));
    end
    step(0, 1, 0, 0, 32'h0, 8'h00);

    // Back-pressure into the skid entry.
    step(1, 0, 0, 0, 32'hA, 8'h01);
    #1;
    check_eq("bp_a_stall", cnt_a, 16'd0);
    step(1, 0, 0, 0, 32'hB, 8'h02);
    #1;
    check_eq("bp_two_ready", rdy_o[0], 1'b0);
    check_eq("bp_b_stall", cnt_a, 16'd1);
    check_eq("bp_head_a", rs_o[0], 32'hA);
    step(1, 0, 0, 0, 32'hC, 8'h03);
    #1;
    check_eq("bp_c_stall", cnt_a, 16'd2);
    step(1, 1, 0, 0, 32'hC, 8'h03);
    #1;
    check_eq("bp_head_b", rs_o[0], 32'hB);
    check_eq("bp_ready_back", rdy_o[0], 1'b1);
    step(1, 1, 0, 0, 32'hC, 8'h03);
    #1;
    check_eq("bp_head_c", rs_o[0], 32'hC);
    check_eq("bp_hold_stall", cnt_a, 16'd2);
    step(0, 1, 0, 0, 32'h0, 8'h00);

    // Flush from TWO together with an offered entry.
    step(1, 0, 0, 0, 32'hD, 8'h10);
    step(1, 0, 0, 0, 32'hE, 8'h20);
    step(1, 0, 1, 0, 32'hF, 8'hFF);
    #1;
    check_eq("flush_valid", vld_o[0], 1'b0);
    check_eq("flush_ctrl", ctrl_o[0], 8'h00);
    check_eq("flush_ready", rdy_o[0], 1'b1);
    check_eq("flush_keeps_stall", cnt_a, 16'd4);
    step(0, 1, 0, 0, 32'h0, 8'h00);
    step(0, 1, 0, 0, 32'h0, 8'h00);
    #1;
    check_eq("flush_gone", vld_o[0], 1'b0);

    // Saturation of the 4-bit counter on the SKID=0 instance.
    step(1, 1, 0, 0, 32'h99, 8'h04);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 32'h0, 8'h00);
    #1;
    check_eq("sat_cnt", cnt_b, 4'd15);
    check_eq("s0_ready_low", rdy_o[1], 1'b0);
    ready_i = 1'b1;
    #1;
    check_eq("s0_ready_comb", rdy_o[1], 1'b1);
    step(1, 1, 0, 0, 32'h77, 8'h08);
    #1;
    check_eq("s0_nobubble_valid", vld_o[1], 1'b1);
    check_eq("s0_nobubble_rs", rs_o[1], 32'h77);
    check_eq("sat_hold", cnt_b, 4'd15);

    // Randomized traffic, occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0,
           ($urandom % 80) == 0, $urandom, 8'($urandom));
    end
    step(0, 1, 0, 0, 32'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
Parametrised, handshaked pipeline stage register for the ID/EX boundary. It replaces a free-running stage register with a valid/ready stage that has an optional 2-entry skid buffer, synchronous flush and bubble insertion. It also keeps a saturating back-pressure counter.
Upstream is the decode/hazard logic; downstream is the EX stage.

Parameters:
DATA_W, 32, width of the rs, rt and immediate data fields
ADDR_W, 5, width of the register address fields
CTRL_W, 8, width of the packed control bundle (bit map in pipe_pkg)
SKID, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o
CNT_W, 16, width of the stall counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  kill all held entries (branch/exception)
valid_i  in  1  upstream entry valid
ready_o  out  1  stage can accept an entry this cycle
rs_data_i  in  DATA_W  source data 1
rt_data_i  in  DATA_W  source data 2
imm_i  in  DATA_W  sign-extended immediate
rs_addr_i  in  ADDR_W  rs register address
rt_addr_i  in  ADDR_W  rt register address
rd_addr_i  in  ADDR_W  rd register address
ctrl_i  in  CTRL_W  control bundle (ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ALUOp[1:0], spare)
valid_o  out  1  output entry valid
ready_i  in  1  downstream accepts this cycle
rs_data_o, rt_data_o, imm_o  out  DATA_W  registered payload
rs_addr_o, rt_addr_o, rd_addr_o  out  ADDR_W  registered payload
ctrl_o  out  CTRL_W  registered control; all zeros whenever valid_o=0
stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

Behaviour:
- Handshake rules:
  - Input transfer = valid_i & ready_o. Output transfer = valid_o & ready_i.
  - Payload is captured only on an input transfer.
  - Payload outputs hold while valid_o & !ready_i.
- Reset (rst_i=1 at a clock edge):
  - valid_o=0, ctrl_o=0, all data/address outputs=0, stall_cnt_o=0.
  - Internal skid entry is invalidated.
  - ready_o=1 from the first cycle after reset.
  - Inputs are ignored while rst_i=1, including reset asserted mid-transfer; in-flight entries are lost.
- SKID=1: states EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
  - ready_o = (state != TWO), registered.
  - EMPTY: on input transfer -> ONE, main <= input.
  - ONE:
    - output transfer with no input transfer -> EMPTY.
    - input transfer with output transfer -> ONE, main <= input.
    - input transfer with no output transfer -> TWO, skid <= input.
  - TWO: no input accepted. On output transfer -> ONE, main <= skid.
  - Order is preserved: skid contents always leave before any newer entry.
  - Latency: 1 cycle from input transfer to valid_o; zero bubbles at full throughput with ready_i held high.
- SKID=0: single register.
  - ready_o = !valid_o | ready_i (combinational).
  - Same 1-cycle latency; no TWO state.
- Flush:
  - flush_i=1 at an edge -> both entries invalid, state EMPTY, valid_o=0, ctrl_o=0.
  - Data/address outputs keep their old values (don't-care).
  - Flush has priority over a simultaneous input transfer; that entry is dropped.
  - A flush in TWO drops both entries. ready_o=1 the following cycle.
  - Reset has priority over flush.
- Bubble: while valid_o=0, ctrl_o is forced to 0, so a downstream stage that ignores valid_o sees a NOP (RegWrite=MemWrite=MemRead=0).
- Stall counter:
  - Increments by 1 on each edge where valid_o=1 and ready_i=0 (sampled pre-edge).
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset; flush does not clear it.
- imm path is the full DATA_W (not 1 bit).

Decomposition:
- pipe_pkg holds:
  - CTRL_W.
  - Control bit positions: ALUSRC=0, MEMTOREG=1, REGWRITE=2, MEMWRITE=3, MEMREAD=4, ALUOP=6:5, bit 7 spare.
  - Skid state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - CTRL_NOP = '0.
- One natural sub-module, pipe_skid_buf: a generic width-W valid/ready skid buffer holding the concatenated payload {rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr, ctrl}.
- The top level adds flush, NOP forcing and the stall counter.

Test Plan:
1. Reset: hold rst_i=1 for 2 cycles with valid_i=1 -> valid_o=0, ctrl_o=0, stall_cnt_o=0; ready_o=1 on the cycle after release.
2. Streaming: ready_i=1, 4 back-to-back entries rs_data_i=0x11..0x44 -> valid_o each cycle from cycle+1, in order, no bubbles.
3. Back-pressure (SKID=1):
   - Drive entries A=0xA, B=0xB with ready_i=0 -> after B, ready_o=0 (TWO) and stall_cnt_o increments each stalled cycle.
   - Raise ready_i -> A then B emitted in order.
   - Input offered during TWO is not lost: it stays pending while ready_o=0 and is accepted afterwards.
4. Flush: in TWO, assert flush_i together with valid_i=1, ctrl_i=0xFF -> next cycle valid_o=0, ctrl_o=0x00, ready_o=1; the flushed entries never appear.
5. Saturation: CNT_W=4, hold valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o stops at 15.
6. SKID=0: ready_i=0 with valid_o=1 -> ready_o=0 in the same cycle; ready_i=1 -> ready_o=1 combinationally and a new entry is captured with no bubble.
